// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x DATA_W register file with a per-register busy
// scoreboard.
//
// A reservation (rsv) marks a destination busy. A writeback (sto) writes data
// and clears the busy bit of every register it writes. A multiply writeback
// (mul) writes both halves of a product at once: dataInExt goes to HI_REG and
// dataIn goes to LO_REG. Reads are combinational. stall flags any in-use read
// port whose register is still busy.
//
// Build option:
//   REGFILE_BYPASS_EN - forward same-cycle writeback data to the read ports.
//                       Without it, written data is visible the cycle after
//                       the write.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   rst                 synchronous reset, active low
//   raddr1/raddr2       read addresses
//   ren1/ren2           read port in use; only affects stall
//   databus1/databus2   read data
//   rbusy1/rbusy2       addressed register has a pending write
//   stall               (ren1 & rbusy1) | (ren2 & rbusy2)
//   rsv/rsv_addr        reserve a destination register
//   rsv_mul             reserve HI_REG and LO_REG; rsv_addr is ignored
//   sto/waddr           writeback strobe and address
//   mul                 dual writeback to HI_REG/LO_REG; waddr is ignored
//   dataIn/dataInExt    write data and upper product half
//   busy_vec            scoreboard, one bit per register
//   wr_err              one-cycle pulse after a writeback to a non-busy register

module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned HI_REG = 3,
    parameter int unsigned LO_REG = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       raddr1,
    input  logic [ADDR_W-1:0]       raddr2,
    input  logic                    ren1,
    input  logic                    ren2,
    output logic [DATA_W-1:0]       databus1,
    output logic [DATA_W-1:0]       databus2,
    output logic                    rbusy1,
    output logic                    rbusy2,
    output logic                    stall,
    input  logic                    rsv,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic                    rsv_mul,
    input  logic                    sto,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic                    mul,
    input  logic [DATA_W-1:0]       dataIn,
    input  logic [DATA_W-1:0]       dataInExt,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wr_err
);

    localparam int unsigned       DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] HI_A  = ADDR_W'(HI_REG);
    localparam logic [ADDR_W-1:0] LO_A  = ADDR_W'(LO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  set_vec;   // registers reserved this cycle
    logic [DEPTH-1:0]  wr_vec;    // registers written this cycle
    logic              err_next;
    logic              wr_err_q;

    // Decode the reservation and writeback targets into one-hot masks.
    always_comb begin
        set_vec = '0;
        wr_vec  = '0;
        if (rsv) begin
            if (rsv_mul) begin
                set_vec[HI_A] = 1'b1;
                set_vec[LO_A] = 1'b1;
            end else begin
                set_vec[rsv_addr] = 1'b1;
            end
        end
        if (sto) begin
            if (mul) begin
                wr_vec[HI_A] = 1'b1;
                wr_vec[LO_A] = 1'b1;
            end else begin
                wr_vec[waddr] = 1'b1;
            end
        end
    end

    // An error is raised only by the busy state before this edge. A
    // reservation in the same cycle cannot excuse a stray writeback.
    assign err_next = |(wr_vec & ~busy_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            if (sto) begin
                if (mul) begin
                    regs[HI_A] <= dataInExt;
                    regs[LO_A] <= dataIn;
                end else begin
                    regs[waddr] <= dataIn;
                end
            end
            // The set term is applied last, so a reservation wins over a
            // writeback to the same register in the same cycle.
            busy_q   <= set_vec | (busy_q & ~wr_vec);
            wr_err_q <= err_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic              fwd1;
    logic              fwd2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    // wr_vec already holds exactly the registers written this cycle. On a
    // multiply, only HI_REG takes the upper half.
    always_comb begin
        fwd1      = wr_vec[raddr1];
        fwd2      = wr_vec[raddr2];
        fwd_data1 = (mul && raddr1 == HI_A) ? dataInExt : dataIn;
        fwd_data2 = (mul && raddr2 == HI_A) ? dataInExt : dataIn;
        databus1  = fwd1 ? fwd_data1 : regs[raddr1];
        databus2  = fwd2 ? fwd_data2 : regs[raddr2];
        rbusy1    = fwd1 ? 1'b0 : busy_q[raddr1];
        rbusy2    = fwd2 ? 1'b0 : busy_q[raddr2];
    end
`else
    always_comb begin
        databus1 = regs[raddr1];
        databus2 = regs[raddr2];
        rbusy1   = busy_q[raddr1];
        rbusy2   = busy_q[raddr2];
    end
`endif

    assign stall    = (ren1 & rbusy1) | (ren2 & rbusy2);
    assign busy_vec = busy_q;
    assign wr_err   = wr_err_q;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter HI_REG, default 3, destination of upper product half.
REQ-004 SHALL have parameter LO_REG, default 0, destination of lower product half; HI_REG != LO_REG.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have ports: raddr1, raddr2  input  ADDR_W  read addresses.
REQ-008 SHALL have ports: ren1, ren2  input  1  read port in use, for stall only.
REQ-009 SHALL have ports: databus1, databus2  output  DATA_W  read data.
REQ-010 SHALL have ports: rbusy1, rbusy2  output  1  addressed register has a pending write.
REQ-011 SHALL have port: stall  output  1  (ren1 & rbusy1) | (ren2 & rbusy2).
REQ-012 SHALL have ports: rsv, rsv_addr, rsv_mul  input  1/ADDR_W/1  reserve a destination; rsv_mul reserves HI_REG and LO_REG and ignores rsv_addr.
REQ-013 SHALL have ports: sto, waddr, mul  input  1/ADDR_W/1  writeback strobe, address, dual-write select.
REQ-014 SHALL have ports: dataIn, dataInExt  input  DATA_W  write data and upper product half.
REQ-015 SHALL have port: busy_vec  output  DEPTH  scoreboard bit per register.
REQ-016 SHALL have port: wr_err  output  1  registered, one-cycle pulse on writeback to a non-busy register.

Function
REQ-017 Register array SHALL be DEPTH x DATA_W flops.
REQ-018 sto=1, mul=0: reg[waddr] <= dataIn at the next edge.
REQ-019 sto=1, mul=1: reg[HI_REG] <= dataInExt and reg[LO_REG] <= dataIn at the same edge; waddr is ignored.
REQ-020 Reads SHALL be combinational from the array: databusN = reg[raddrN]; rbusyN = busy_vec[raddrN].
REQ-021 rsv=1 SHALL set the busy bit(s) at the next edge: rsv_addr, or HI_REG and LO_REG when rsv_mul=1.
REQ-022 A writeback SHALL clear the busy bit of every register it writes at the next edge.
REQ-023 Reservation and writeback to the same register in the same cycle: reservation wins and the bit stays 1; data is still written.
REQ-024 Reservation of a register that is already busy: bit stays 1 and no error is flagged.
REQ-025 Writeback to any written register whose busy bit is 0: data is written and wr_err=1 the following cycle.
REQ-026 stall SHALL be purely combinational from current busy_vec, raddrN and renN; a same-cycle writeback does not clear it.
REQ-027 sto=0 SHALL leave the array unchanged regardless of mul, waddr and data inputs.

Reset
REQ-028 rst=0 at a rising edge SHALL clear all registers, busy_vec and wr_err to 0, overriding sto and rsv.
REQ-029 After reset: databus1=databus2=0, rbusy1=rbusy2=0, stall=0.
REQ-030 A reset during pending reservations SHALL drop them; no writeback is required afterwards.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined: when sto=1 writes raddrN this cycle, databusN = incoming data (dataIn, or dataInExt for HI_REG when mul=1) and rbusyN=0 and stall excludes that port; otherwise as REQ-020.
REQ-033 Without REGFILE_BYPASS_EN: REQ-020 and REQ-026 apply unchanged and new data is visible the cycle after the write.

Verification
REQ-034 Reset, write 0xDEADBEEF to r5, read raddr1=5 next cycle -> databus1=0xDEADBEEF, busy_vec=0.
REQ-035 sto=1, mul=1, dataIn=0x1111, dataInExt=0x2222 -> next cycle reg[0]=0x1111, reg[3]=0x2222, other registers unchanged.
REQ-036 rsv=1, rsv_addr=2; next cycle ren1=1, raddr1=2 -> rbusy1=1, stall=1; writeback r2 -> bit cleared, stall=0 one cycle later.
REQ-037 Same-cycle rsv r4 and writeback r4=0x55 -> reg[4]=0x55, busy_vec[4]=1; writeback r6 with bit clear -> wr_err pulses 1 for one cycle.
REQ-038 rsv_mul=1 then rst=0 for one edge -> busy_vec=0, all registers 0, wr_err=0.
REQ-039 With REGFILE_BYPASS_EN: sto=1, waddr=1, dataIn=0xA5A5A5A5, raddr2=1 same cycle -> databus2=0xA5A5A5A5; without the macro -> old value.
